// File: rtl/id_ex_pkg.sv
// Shared types and defaults for the ID/EX pipeline register stage.
package id_ex_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ALU_CTRL_W_DEF = 4;

    // Field order matches the flat packing used inside id_ex_stage.
    typedef struct packed {
        logic                      load;
        logic                      store;
        logic                      next_sel;
        logic                      branch_result;
        logic [ALU_CTRL_W_DEF-1:0] alu_control;
        logic [1:0]                mem_to_reg;
        logic [XLEN_DEF-1:0]       opa;
        logic [XLEN_DEF-1:0]       opb;
        logic [XLEN_DEF-1:0]       opb_data;
    } payload_t;

    function automatic int payload_w(input int xlen, input int alu_ctrl_w);
        return 4 + alu_ctrl_w + 2 + 3 * xlen;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: payload register plus valid bit. load wins over clear;
// clearing only drops the valid bit so the payload keeps its last value.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and flush.
// Define ID_EX_SKID_EN for a main+skid slot pair with registered in_ready.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  load_in,
    input  logic                  store_in,
    input  logic                  next_sel_in,
    input  logic                  branch_result_in,
    input  logic [ALU_CTRL_W-1:0] alu_control_in,
    input  logic [1:0]            mem_to_reg_in,
    input  logic [XLEN-1:0]       opa_in,
    input  logic [XLEN-1:0]       opb_in,
    input  logic [XLEN-1:0]       opb_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  load,
    output logic                  store,
    output logic                  next_sel,
    output logic                  branch_result,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            mem_to_reg,
    output logic [XLEN-1:0]       opa_out,
    output logic [XLEN-1:0]       opb_out,
    output logic [XLEN-1:0]       opb_data_out
);

    localparam int PW = payload_w(XLEN, ALU_CTRL_W);

    logic [PW-1:0] in_d, main_d;
    logic          main_v;
    logic          accept, xfer;
    logic          ld_q, st_q, ns_q, br_q;

    assign in_d = {load_in, store_in, next_sel_in, branch_result_in,
                   alu_control_in, mem_to_reg_in, opa_in, opb_in, opb_data_in};

    assign accept    = in_valid && in_ready;
    assign xfer      = main_v && out_ready;
    assign out_valid = main_v;

`ifdef ID_EX_SKID_EN
    logic [PW-1:0] skid_d, main_din;
    logic          skid_v, main_free, main_load, skid_load;

    // skid_v is a flop, so in_ready never depends combinationally on out_ready.
    assign in_ready  = !skid_v;
    assign main_free = !main_v || out_ready;
    assign main_load = !flush && main_free && (skid_v || accept);
    assign main_din  = skid_v ? skid_d : in_d;
    assign skid_load = !flush && accept && main_v && !out_ready;

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (flush || xfer),
        .d     (main_din),
        .q     (main_d),
        .valid (main_v)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (flush || xfer),
        .d     (in_d),
        .q     (skid_d),
        .valid (skid_v)
    );
`else
    assign in_ready = !main_v || out_ready;

    pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && !flush),
        .clear (flush || xfer),
        .d     (in_d),
        .q     (main_d),
        .valid (main_v)
    );
`endif

    assign {ld_q, st_q, ns_q, br_q, alu_control, mem_to_reg,
            opa_out, opb_out, opb_data_out} = main_d;

    // Control bits read as a bubble whenever the stage is empty.
    assign load          = ld_q && main_v;
    assign store         = st_q && main_v;
    assign next_sel      = ns_q && main_v;
    assign branch_result = br_q && main_v;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a queue-based occupancy model.
module tb_id_ex_stage;
    import id_ex_pkg::*;

`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    payload_t din = '0;
    payload_t obs;
    logic load, store, next_sel, branch_result;
    logic [ALU_CTRL_W_DEF-1:0] alu_control;
    logic [1:0] mem_to_reg;
    logic [XLEN_DEF-1:0] opa_out, opb_out, opb_data_out;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .load_in(din.load), .store_in(din.store), .next_sel_in(din.next_sel),
        .branch_result_in(din.branch_result), .alu_control_in(din.alu_control),
        .mem_to_reg_in(din.mem_to_reg), .opa_in(din.opa), .opb_in(din.opb),
        .opb_data_in(din.opb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .load(load), .store(store), .next_sel(next_sel), .branch_result(branch_result),
        .alu_control(alu_control), .mem_to_reg(mem_to_reg),
        .opa_out(opa_out), .opb_out(opb_out), .opb_data_out(opb_data_out)
    );

    assign obs = {load, store, next_sel, branch_result, alu_control, mem_to_reg,
                  opa_out, opb_out, opb_data_out};

    // Model: beats currently held, oldest first, plus the last payload seen at the head.
    payload_t q[$];
    payload_t held = '0;
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic payload_t rnd();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(payload_t)-1:0];
    endfunction

    function automatic payload_t with_opa(input int v);
        payload_t p;
        p     = rnd();
        p.opa = v;
        return p;
    endfunction

    // Called at a falling edge: drive, check, clock, update the model.
    task automatic step(input logic v, input logic r, input logic f, input payload_t p);
        logic     exp_rdy;
        payload_t bub;
        in_valid = v; out_ready = r; flush = f; din = p;
        #2;
        exp_rdy = (CAP == 1) ? (q.size() == 0 || r) : (q.size() < CAP);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
        if (q.size() != 0) begin
            chk("payload", 128'(obs), 128'(q[0]));
        end else begin
            bub = held;
            bub.load = 1'b0; bub.store = 1'b0; bub.next_sel = 1'b0; bub.branch_result = 1'b0;
            chk("bubble", 128'(obs), 128'(bub));
        end
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(p);
        end
        if (q.size() != 0) held = q[0];
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_opa", 128'(opa_out), 128'(0));
        chk("rst_load", 128'(load), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        held = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        payload_t p;
        @(negedge clk);
        chk("init_in_ready", 128'(in_ready), 128'(1));
        chk("init_out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // streaming, opa 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, with_opa(i));
            chk("stream_opa", 128'(opa_out), 128'(i));
        end
        step(1'b0, 1'b1, 1'b0, rnd());

        // stall: A5 held, A6 goes to skid when available
        step(1'b1, 1'b1, 1'b0, with_opa('hA5));
        step(1'b1, 1'b0, 1'b0, with_opa('hA6));
        step(1'b1, 1'b0, 1'b0, with_opa('hA7));
        step(1'b0, 1'b0, 1'b0, rnd());
        chk("stall_opa", 128'(opa_out), 128'('hA5));
        chk("stall_valid", 128'(out_valid), 128'(1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, rnd());

        // flush with a stalled beat and a concurrent 0x55
        p = rnd(); p.store = 1'b1;
        step(1'b1, 1'b1, 1'b0, p);
        step(1'b0, 1'b0, 1'b0, rnd());
        step(1'b1, 1'b0, 1'b1, with_opa('h55));
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_store", 128'(store), 128'(0));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, rnd());

        // bubble after a load beat
        p = rnd(); p.load = 1'b1; p.opa = 'h77;
        step(1'b1, 1'b1, 1'b0, p);
        step(1'b0, 1'b1, 1'b0, rnd());
        chk("bubble_valid", 128'(out_valid), 128'(0));
        chk("bubble_load", 128'(load), 128'(0));
        chk("bubble_opa", 128'(opa_out), 128'('h77));

        // reset mid-stall discards held beats
        step(1'b1, 1'b1, 1'b0, rnd());
        step(1'b1, 1'b0, 1'b0, rnd());
        do_reset();
        step(1'b1, 1'b1, 1'b0, with_opa('h3C));
        chk("post_rst_opa", 128'(opa_out), 128'('h3C));

        // random traffic with occasional flush and one mid-run reset
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), rnd());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
